// File: rtl/signal_generator.sv
// Burst pattern source for the MII-style test path: emits DATA/CTRL character words
// per a lane-mapping mode, with single-lane error injection and transmit-side counters.
module signal_generator #(
  parameter int unsigned DATA_WIDTH        = 64,
  parameter logic [7:0]  DATA_CHAR_PATTERN = 8'hAA,
  parameter logic [7:0]  CTRL_CHAR_PATTERN = 8'h55,
  localparam int unsigned LANES  = DATA_WIDTH / 8,
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           burst_len,
  input  logic [1:0]            mode,
  input  logic [LANES-1:0]      ctrl_mask,
  input  logic                  stop,
  input  logic                  inj_err,
  input  logic [LANE_W-1:0]     err_lane,
  input  logic                  clr_counters,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LANES-1:0]      ctrl_out,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           total_char_count,
  output logic [31:0]           data_char_count,
  output logic [31:0]           ctrl_char_count,
  output logic [31:0]           data_err_inj_count,
  output logic [31:0]           ctrl_err_inj_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            mode_q, mode_d;
  logic [LANES-1:0]      mask_q, mask_d;
  logic [15:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LANES-1:0]      ctrl_q, ctrl_d;
  logic [31:0]           cnt_total_q, cnt_total_d;
  logic [31:0]           cnt_data_q, cnt_data_d;
  logic [31:0]           cnt_ctrl_q, cnt_ctrl_d;
  logic [31:0]           cnt_derr_q, cnt_derr_d;
  logic [31:0]           cnt_cerr_q, cnt_cerr_d;

  // Word-generator controls, driven by the FSM for the word registered on this edge.
  logic                  emit;
  logic [15:0]           gen_idx;
  logic [1:0]            gen_mode;
  logic [LANES-1:0]      gen_mask;
  logic                  gen_err;
  logic [LANE_W-1:0]     gen_lane;
  logic [DATA_WIDTH-1:0] gen_data;
  logic [LANES-1:0]      gen_ctrl;
  logic                  gen_err_data;
  logic                  gen_err_ctrl;
  logic [31:0]           gen_ctrl_lanes;

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    mode_d   = mode_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    emit     = 1'b0;
    gen_idx  = idx_q + 16'd1;
    gen_mode = mode_q;
    gen_mask = mask_q;
    gen_err  = 1'b0;
    gen_lane = err_lane;
    unique case (state_q)
      S_IDLE: begin
        if (start && (burst_len != 16'd0)) begin
          len_d    = burst_len;
          mode_d   = mode;
          mask_d   = ctrl_mask;
          idx_d    = 16'd0;
          gen_idx  = 16'd0;
          gen_mode = mode;
          gen_mask = ctrl_mask;
          emit     = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // An injection request is consumed by the word registered on the same edge;
        // on a stop or end-of-burst edge no word follows, so the request is dropped.
        if (stop) begin
          state_d = S_IDLE;
        end else if (idx_q == len_q - 16'd1) begin
          state_d = S_DONE;
        end else begin
          emit    = 1'b1;
          idx_d   = idx_q + 16'd1;
          gen_err = inj_err;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gen_data     = '0;
    gen_ctrl     = '0;
    gen_err_data = 1'b0;
    gen_err_ctrl = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      unique case (gen_mode)
        2'd0:    gen_ctrl[i] = 1'b0;
        2'd1:    gen_ctrl[i] = 1'b1;
        2'd2:    gen_ctrl[i] = gen_idx[0];
        default: gen_ctrl[i] = gen_mask[i];
      endcase
      gen_data[8*i +: 8] = gen_ctrl[i] ? CTRL_CHAR_PATTERN : DATA_CHAR_PATTERN;
      if (gen_err && (gen_lane == LANE_W'(i))) begin
        gen_data[8*i +: 8] = gen_data[8*i +: 8] ^ 8'hFF;
        gen_err_ctrl       = gen_ctrl[i];
        gen_err_data       = ~gen_ctrl[i];
      end
    end
  end

  assign gen_ctrl_lanes = 32'($countones(gen_ctrl));
  assign data_d         = emit ? gen_data : '0;
  assign ctrl_d         = emit ? gen_ctrl : '0;

  // Clear has priority over the increment of a word registered on the same edge.
  always_comb begin
    cnt_total_d = cnt_total_q;
    cnt_data_d  = cnt_data_q;
    cnt_ctrl_d  = cnt_ctrl_q;
    cnt_derr_d  = cnt_derr_q;
    cnt_cerr_d  = cnt_cerr_q;
    if (clr_counters) begin
      cnt_total_d = '0;
      cnt_data_d  = '0;
      cnt_ctrl_d  = '0;
      cnt_derr_d  = '0;
      cnt_cerr_d  = '0;
    end else if (emit) begin
      cnt_total_d = cnt_total_q + 32'(LANES);
      cnt_ctrl_d  = cnt_ctrl_q + gen_ctrl_lanes;
      cnt_data_d  = cnt_data_q + (32'(LANES) - gen_ctrl_lanes);
      cnt_derr_d  = cnt_derr_q + {31'd0, gen_err_data};
      cnt_cerr_d  = cnt_cerr_q + {31'd0, gen_err_ctrl};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      mode_q      <= '0;
      mask_q      <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      ctrl_q      <= '0;
      cnt_total_q <= '0;
      cnt_data_q  <= '0;
      cnt_ctrl_q  <= '0;
      cnt_derr_q  <= '0;
      cnt_cerr_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      cnt_total_q <= cnt_total_d;
      cnt_data_q  <= cnt_data_d;
      cnt_ctrl_q  <= cnt_ctrl_d;
      cnt_derr_q  <= cnt_derr_d;
      cnt_cerr_q  <= cnt_cerr_d;
    end
  end

  assign data_out           = data_q;
  assign ctrl_out           = ctrl_q;
  assign busy               = (state_q == S_RUN);
  assign done               = (state_q == S_DONE);
  assign total_char_count   = cnt_total_q;
  assign data_char_count    = cnt_data_q;
  assign ctrl_char_count    = cnt_ctrl_q;
  assign data_err_inj_count = cnt_derr_q;
  assign ctrl_err_inj_count = cnt_cerr_q;

endmodule

// File: tb/tb_signal_generator.sv
// Directed bench for signal_generator: expected words are queued at burst start and
// popped as the DUT puts them on the bus; counters follow a bench-side model.
module tb_signal_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] burst_len;
  logic [1:0]  mode;
  logic [7:0]  ctrl_mask;
  logic        stop;
  logic        inj_err;
  logic [2:0]  err_lane;
  logic        clr_counters;
  logic [63:0] data_out;
  logic [7:0]  ctrl_out;
  logic        busy;
  logic        done;
  logic [31:0] total_char_count;
  logic [31:0] data_char_count;
  logic [31:0] ctrl_char_count;
  logic [31:0] data_err_inj_count;
  logic [31:0] ctrl_err_inj_count;

  signal_generator #(
    .DATA_WIDTH        (64),
    .DATA_CHAR_PATTERN (8'hAA),
    .CTRL_CHAR_PATTERN (8'h55)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .burst_len          (burst_len),
    .mode               (mode),
    .ctrl_mask          (ctrl_mask),
    .stop               (stop),
    .inj_err            (inj_err),
    .err_lane           (err_lane),
    .clr_counters       (clr_counters),
    .data_out           (data_out),
    .ctrl_out           (ctrl_out),
    .busy               (busy),
    .done               (done),
    .total_char_count   (total_char_count),
    .data_char_count    (data_char_count),
    .ctrl_char_count    (ctrl_char_count),
    .data_err_inj_count (data_err_inj_count),
    .ctrl_err_inj_count (ctrl_err_inj_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ctrl;
    bit          ed;
    bit          ec;
  } word_t;

  word_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_total, m_data, m_ctrl, m_derr, m_cerr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic word_t model_word(input int k, input logic [1:0] m, input logic [7:0] mask,
                                       input int lane);
    word_t w;
    logic  c;
    w.data = '0;
    w.ctrl = '0;
    w.ed   = 1'b0;
    w.ec   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      case (m)
        2'd0:    c = 1'b0;
        2'd1:    c = 1'b1;
        2'd2:    c = (k % 2 == 1);
        default: c = mask[i];
      endcase
      w.ctrl[i]        = c;
      w.data[8*i +: 8] = c ? 8'h55 : 8'hAA;
      if (lane == i) begin
        w.data[8*i +: 8] = ~w.data[8*i +: 8];
        w.ed = !c;
        w.ec = c;
      end
    end
    return w;
  endfunction

  task automatic zero_model();
    m_total = '0; m_data = '0; m_ctrl = '0; m_derr = '0; m_cerr = '0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_total"}, 64'(total_char_count), 64'(m_total));
    check({tag, "_data"},  64'(data_char_count),  64'(m_data));
    check({tag, "_ctrl"},  64'(ctrl_char_count),  64'(m_ctrl));
    check({tag, "_derr"},  64'(data_err_inj_count), 64'(m_derr));
    check({tag, "_cerr"},  64'(ctrl_err_inj_count), 64'(m_cerr));
  endtask

  task automatic clear_counters();
    @(negedge clk);
    clr_counters = 1'b1;
    @(negedge clk);
    clr_counters = 1'b0;
    zero_model();
    check_counters("clear");
  endtask

  // inj_at/stop_at/clr_at name the visible word index during which the input is raised (-1: never).
  task automatic run_burst(input int len, input logic [1:0] m, input logic [7:0] mask,
                           input int inj_at, input int inj_lane, input int stop_at,
                           input int clr_at, input bit poke);
    int    nwords;
    int    k;
    int    guard;
    bit    stopped;
    word_t e;
    stopped = (stop_at >= 0) && (stop_at < len);
    nwords  = stopped ? stop_at + 1 : len;
    for (int j = 0; j < nwords; j++)
      exp_q.push_back(model_word(j, m, mask, (inj_at >= 0 && j == inj_at + 1) ? inj_lane : -1));
    @(negedge clk);
    start = 1'b1; burst_len = 16'(len); mode = m; ctrl_mask = mask;
    @(negedge clk);
    start = 1'b0; burst_len = 16'($urandom); mode = 2'($urandom); ctrl_mask = 8'($urandom);
    k = 0;
    guard = 0;
    while (busy && guard < 200) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
        e = '{default: '0};
      end else begin
        e = exp_q.pop_front();
      end
      check("word_data", data_out, e.data);
      check("word_ctrl", 64'(ctrl_out), 64'(e.ctrl));
      if (clr_at >= 0 && k == clr_at + 1) begin
        zero_model();
      end else begin
        m_total += 32'd8;
        m_ctrl  += 32'($countones(e.ctrl));
        m_data  += 32'(8 - $countones(e.ctrl));
        m_derr  += {31'd0, e.ed};
        m_cerr  += {31'd0, e.ec};
      end
      check("running_total", 64'(total_char_count), 64'(m_total));
      inj_err      = (k == inj_at);
      err_lane     = 3'(inj_lane);
      stop         = (k == stop_at);
      clr_counters = (k == clr_at);
      start        = poke && (k == 1);
      @(negedge clk);
      k++;
      guard++;
    end
    inj_err = 1'b0; stop = 1'b0; clr_counters = 1'b0; start = 1'b0;
    check("word_count", 64'(k), 64'(nwords));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check("busy_after", 64'(busy), 64'd0);
    check("bus_after", data_out, 64'd0);
    check("ctrl_after", 64'(ctrl_out), 64'd0);
    if (stopped) check("no_done_on_stop", 64'(done), 64'd0);
    else         check("done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check("done_cleared", 64'(done), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
    check_counters("burst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t e;
    rst_n = 1'b0; start = 1'b0; burst_len = '0; mode = '0; ctrl_mask = '0;
    stop = 1'b0; inj_err = 1'b0; err_lane = '0; clr_counters = 1'b0;
    zero_model();

    // Reset held while every input toggles.
    repeat (4) begin
      @(negedge clk);
      start = 1'($urandom); burst_len = 16'($urandom); mode = 2'($urandom);
      ctrl_mask = 8'($urandom); stop = 1'($urandom); inj_err = 1'($urandom);
      err_lane = 3'($urandom); clr_counters = 1'($urandom);
      check("rst_data", data_out, 64'd0);
      check("rst_ctrl", 64'(ctrl_out), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check_counters("rst");
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; inj_err = 1'b0; clr_counters = 1'b0;
    rst_n = 1'b1;

    // Mode 0, four data words.
    clear_counters();
    run_burst(4, 2'd0, 8'h00, -1, 0, -1, -1, 1'b0);
    check("m0_total", 64'(total_char_count), 64'd32);
    check("m0_data",  64'(data_char_count),  64'd32);
    check("m0_ctrl",  64'(ctrl_char_count),  64'd0);

    // Mode 2, alternating words.
    clear_counters();
    run_burst(3, 2'd2, 8'h00, -1, 0, -1, -1, 1'b0);
    check("m2_total", 64'(total_char_count), 64'd24);
    check("m2_data",  64'(data_char_count),  64'd16);
    check("m2_ctrl",  64'(ctrl_char_count),  64'd8);

    // Mode 3 with injection into a control lane, then a data lane.
    clear_counters();
    run_burst(4, 2'd3, 8'h0F, 0, 2, -1, -1, 1'b0);
    check("inj2_cerr", 64'(ctrl_err_inj_count), 64'd1);
    check("inj2_derr", 64'(data_err_inj_count), 64'd0);
    clear_counters();
    run_burst(4, 2'd3, 8'h0F, 0, 6, -1, -1, 1'b0);
    check("inj6_derr", 64'(data_err_inj_count), 64'd1);
    check("inj6_cerr", 64'(ctrl_err_inj_count), 64'd0);

    // Mode 1 aborted by stop during word 3.
    clear_counters();
    run_burst(10, 2'd1, 8'h00, -1, 0, 3, -1, 1'b0);
    check("stop_ctrl",  64'(ctrl_char_count),  64'd32);
    check("stop_total", 64'(total_char_count), 64'd32);

    // Zero-length start is ignored.
    @(negedge clk);
    start = 1'b1; burst_len = 16'd0; mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_bus", data_out, 64'd0);
    @(negedge clk);
    check("len0_busy_later", 64'(busy), 64'd0);
    check("len0_total", 64'(total_char_count), 64'd32);

    // Start pulsed mid-burst is ignored; an injection late in a burst still lands.
    run_burst(5, 2'd2, 8'h00, 2, 1, -1, -1, 1'b1);

    // Clear coincident with the edge registering word 3.
    clear_counters();
    run_burst(6, 2'd3, 8'hA5, -1, 0, -1, 2, 1'b0);
    check("clr_total", 64'(total_char_count), 64'd16);

    // Reset during word 5 of a 20-word burst.
    clear_counters();
    for (int j = 0; j < 20; j++) exp_q.push_back(model_word(j, 2'd0, 8'h00, -1));
    @(negedge clk);
    start = 1'b1; burst_len = 16'd20; mode = 2'd0; ctrl_mask = 8'h00;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      e = exp_q.pop_front();
      check("pre_rst_word", data_out, e.data);
      if (k < 5) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    zero_model();
    check("midrst_data", data_out, 64'd0);
    check("midrst_ctrl", 64'(ctrl_out), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check_counters("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(2, 2'd0, 8'h00, -1, 0, -1, -1, 1'b0);
    check("post_rst_total", 64'(total_char_count), 64'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
